// File: rtl/tcu_drl_acc_sched.sv
// rtl/tcu_drl_acc_sched.sv - multi-step dot-product job sequencer for the DRL significand accumulator
module tcu_drl_acc_sched #(
    parameter int N         = 5,
    parameter int W         = 25 + $clog2(N) + 1,
    parameter int MAX_STEPS = 8,
    parameter int DP_LAT    = 2,
    parameter int AW        = W + $clog2(MAX_STEPS + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [$clog2(MAX_STEPS+1)-1:0] i_req_steps,
    input  logic                           i_req_fmt,
    input  logic [24:0]                    i_req_c,
    input  logic                           i_op_valid,
    output logic                           o_op_ready,
    input  logic [(N-1)*25-1:0]            i_op_sigs,
    output logic                           o_dp_valid,
    output logic [N*25-1:0]                o_dp_sigs,
    output logic                           o_dp_fmt,
    input  logic                           i_dp_res_valid,
    input  logic [W-1:0]                   i_dp_res,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [AW-1:0]                  o_rsp_sig,
    output logic                           o_rsp_fmt
);

    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int GW = $clog2(DP_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [SW-1:0]       r_steps;
    logic                r_fmt;
    logic [24:0]         r_c;
    logic [AW-1:0]       r_acc;
    logic [SW-1:0]       r_issued;
    logic [SW-1:0]       r_returned;
    logic [GW-1:0]       r_guard;
    logic                r_req_ready;
    logic                r_op_ready;
    logic                r_dp_valid;
    logic [N*25-1:0]     r_dp_sigs;
    logic                r_dp_fmt;
    logic                r_rsp_valid;
    logic [AW-1:0]       r_rsp_sig;
    logic                r_rsp_fmt;

    logic [SW-1:0]       w_req_steps;
    logic                w_live;
    logic                w_take;
    logic [AW-1:0]       w_acc_next;
    logic [SW-1:0]       w_ret_next;
    logic                w_last_issue;
    logic [24:0]         w_c_slot;

    function automatic logic [AW-1:0] ext_c(input logic fmt, input logic [24:0] c);
        ext_c = {{(AW-25){~fmt & c[24]}}, c};
    endfunction

    function automatic logic [AW-1:0] ext_res(input logic fmt, input logic [W-1:0] r);
        ext_res = {{(AW-W){~fmt & r[W-1]}}, r};
    endfunction

    assign w_req_steps  = (i_req_steps > SW'(MAX_STEPS)) ? SW'(MAX_STEPS) : i_req_steps;
    assign w_live       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    // Results still in flight from before a reset must not leak into the next job
    assign w_take       = i_dp_res_valid && w_live && (r_guard == '0);
    assign w_acc_next   = r_acc + (w_take ? ext_res(r_fmt, i_dp_res) : {AW{1'b0}});
    assign w_ret_next   = r_returned + {{(SW-1){1'b0}}, w_take};
    assign w_last_issue = ((r_issued + SW'(1)) == r_steps);
    assign w_c_slot     = (r_issued == '0) ? r_c : 25'd0;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_steps     <= '0;
            r_fmt       <= 1'b0;
            r_c         <= '0;
            r_acc       <= '0;
            r_issued    <= '0;
            r_returned  <= '0;
            r_guard     <= GW'(DP_LAT);
            r_req_ready <= 1'b1;
            r_op_ready  <= 1'b0;
            r_dp_valid  <= 1'b0;
            r_dp_sigs   <= '0;
            r_dp_fmt    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_sig   <= '0;
            r_rsp_fmt   <= 1'b0;
        end else begin
            r_dp_valid <= 1'b0;
            if (r_guard != '0) begin
                r_guard <= r_guard - GW'(1);
            end
            if (w_take) begin
                r_acc      <= w_acc_next;
                r_returned <= w_ret_next;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_steps     <= w_req_steps;
                        r_fmt       <= i_req_fmt;
                        r_c         <= i_req_c;
                        r_issued    <= '0;
                        r_returned  <= '0;
                        r_req_ready <= 1'b0;
                        if (w_req_steps == '0) begin
                            r_acc       <= ext_c(i_req_fmt, i_req_c);
                            r_rsp_sig   <= ext_c(i_req_fmt, i_req_c);
                            r_rsp_fmt   <= i_req_fmt;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_acc      <= '0;
                            r_op_ready <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_op_valid) begin
                        r_dp_valid <= 1'b1;
                        r_dp_sigs  <= {w_c_slot, i_op_sigs};
                        r_dp_fmt   <= r_fmt;
                        r_issued   <= r_issued + SW'(1);
                        if (w_last_issue) begin
                            r_op_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The result arriving this cycle is folded into the response directly
                    if (w_ret_next == r_steps) begin
                        r_rsp_sig   <= w_acc_next;
                        r_rsp_fmt   <= r_fmt;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_op_ready  <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_op_ready  = r_op_ready;
    assign o_dp_valid  = r_dp_valid;
    assign o_dp_sigs   = r_dp_sigs;
    assign o_dp_fmt    = r_dp_fmt;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_sig   = r_rsp_sig;
    assign o_rsp_fmt   = r_rsp_fmt;

endmodule

// File: doc/tcu_drl_acc_sched.md
Name: tcu_drl_acc_sched

Overview:
Sequences one multi-step dot-product job through the TCU DRL significand accumulator datapath (N-operand CSA, N-1 product slots plus one C slot).
- Accepts a job descriptor, then streams one product chunk per cycle into the datapath.
- Injects the C term on the first step only.
- Sums the returned W-bit partial sums into a wider accumulator and emits one result per job.
- Sits between the TCU operand/product stage and the normalisation/rounding stage.

Parameters:
N, 5, datapath operand count including the C slot
W, 25+$clog2(N)+1, datapath result width
MAX_STEPS, 8, maximum chunks per job
DP_LAT, 2, fixed cycles from dp_valid to dp_res_valid (≥1)
AW, W+$clog2(MAX_STEPS+1), final accumulator width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
req_valid  in  1  job descriptor valid
req_ready  out  1  scheduler can accept a job
req_steps  in  $clog2(MAX_STEPS+1)  chunk count, 0..MAX_STEPS
req_fmt  in  1  1 = unsigned (zero-extend), 0 = signed (sign-extend)
req_c  in  25  C significand
op_valid  in  1  product chunk valid
op_ready  out  1  chunk accepted this cycle
op_sigs  in  (N-1)*25  N-1 product significands
dp_valid  out  1  datapath issue strobe
dp_sigs  out  N*25  datapath operands; slot N-1 = C slot
dp_fmt  out  1  datapath fmt_sel
dp_res_valid  in  1  datapath result strobe
dp_res  in  W  datapath sum
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer ready
rsp_sig  out  AW  accumulated result
rsp_fmt  out  1  fmt of the completed job

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; issued=0, returned=0, acc=0. Outputs: req_ready=1, op_ready=0, dp_valid=0, dp_sigs=0, dp_fmt=0, rsp_valid=0, rsp_sig=0, rsp_fmt=0. Reset mid-job discards the job; any dp_res_valid within DP_LAT after reset is ignored.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid:
  - Latch steps, fmt and c; set acc=0, issued=0, returned=0.
  - steps==0: acc=ext(c) and go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: op_ready=1.
  - Each cycle with op_valid&&op_ready, the next cycle drives dp_valid=1 and dp_sigs={C slot, op_sigs}, then issued++.
  - C slot = latched c when issued==0, else 0. dp_fmt = latched fmt.
  - Registered output: issue latency is exactly 1 cycle after the handshake.
  - When the handshake accepts the chunk with issued==steps-1, go to DRAIN. No bubbles are required; back-to-back chunks issue one per cycle.
- DRAIN: op_ready=0. Go to RESP on the cycle returned reaches steps.
- Any state, on dp_res_valid while a job is live: acc += ext(dp_res), returned++.
  - ext = zero-extend to AW if fmt=1, sign-extend from bit W-1 if fmt=0.
  - Arithmetic is modulo 2^AW; no overflow is possible by construction.
- RESP: rsp_valid=1, rsp_sig=acc, rsp_fmt=fmt, held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE. req_ready=0 in RESP, so there is no same-cycle restart.
- dp_res_valid is counted in the cycle it arrives, including the same cycle as the final issue or the RESP transition. Results arrive in issue order.
- dp_res_valid when no job is live (IDLE/RESP) is ignored.
- req_steps > MAX_STEPS is clamped to MAX_STEPS.
- req_ready=0 outside IDLE; op_ready=0 outside ISSUE.

Test Plan:
- Reset hold → all outputs at reset values; req_ready=1; stray dp_res_valid ignored; acc stays 0.
- Signed job: steps=1, c=25'h0000010, products all 25'h0000001, model datapath sums slots (DP_LAT=2) → dp_sigs C slot=0x10; rsp_sig=0x14 (N=5); rsp_valid 1 cycle after the result returns.
- steps=3, op_valid continuous → dp_valid high 3 consecutive cycles; C slot nonzero only on the first; rsp_sig = sum of the 3 dp_res values.
- Signed negative: fmt=0, dp_res=W'(-5) twice → rsp_sig = AW'(-10). Same dp_res with fmt=1 → rsp_sig = 2*(2^W-5), zero-extended.
- steps=0, c=25'h1FFFFFF, fmt=0 → RESP immediately with rsp_sig = AW'(-1); no dp_valid pulse.
- Backpressure: op_valid toggled, rsp_ready held 0 for 5 cycles → issue only on handshakes; rsp_sig stable; next req accepted only after rsp_ready. Reset asserted mid-ISSUE → returns to IDLE with no rsp.
